// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared definitions for the keypad letter entry block: FSM state enum,
//   key identifiers, the one-hot {row, col} codes produced by the keypad
//   scanner, and the ASCII base letter for each letter key.
//   cur_key layout: {row[3:0], col[3:0]}, bit 7 = row0, bit 3 = col0.
`timescale 1ns/1ps
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TAP     = 2'd1,
    ST_PENDING = 2'd2
  } state_e;

  // Row / column one-hot nibbles (MSB of each nibble is row0 / col0)
  localparam logic [3:0] ROW0 = 4'b1000;
  localparam logic [3:0] ROW1 = 4'b0100;
  localparam logic [3:0] ROW2 = 4'b0010;
  localparam logic [3:0] ROW3 = 4'b0001;
  localparam logic [3:0] COL0 = 4'b1000;
  localparam logic [3:0] COL1 = 4'b0100;
  localparam logic [3:0] COL2 = 4'b0010;
  localparam logic [3:0] COL3 = 4'b0001;

  // Full key codes as seen on cur_key
  localparam logic [7:0] CODE_1    = {ROW0, COL0};
  localparam logic [7:0] CODE_2    = {ROW0, COL1};
  localparam logic [7:0] CODE_3    = {ROW0, COL2};
  localparam logic [7:0] CODE_A    = {ROW0, COL3};
  localparam logic [7:0] CODE_4    = {ROW1, COL0};
  localparam logic [7:0] CODE_5    = {ROW1, COL1};
  localparam logic [7:0] CODE_6    = {ROW1, COL2};
  localparam logic [7:0] CODE_B    = {ROW1, COL3};
  localparam logic [7:0] CODE_7    = {ROW2, COL0};
  localparam logic [7:0] CODE_8    = {ROW2, COL1};
  localparam logic [7:0] CODE_9    = {ROW2, COL2};
  localparam logic [7:0] CODE_C    = {ROW2, COL3};
  localparam logic [7:0] CODE_STAR = {ROW3, COL0};
  localparam logic [7:0] CODE_0    = {ROW3, COL1};
  localparam logic [7:0] CODE_HASH = {ROW3, COL2};
  localparam logic [7:0] CODE_D    = {ROW3, COL3};

  // Key identifiers: digits map to their value, A-D to 10-13
  localparam logic [3:0] KEY_0    = 4'd0;
  localparam logic [3:0] KEY_1    = 4'd1;
  localparam logic [3:0] KEY_2    = 4'd2;
  localparam logic [3:0] KEY_3    = 4'd3;
  localparam logic [3:0] KEY_4    = 4'd4;
  localparam logic [3:0] KEY_5    = 4'd5;
  localparam logic [3:0] KEY_6    = 4'd6;
  localparam logic [3:0] KEY_7    = 4'd7;
  localparam logic [3:0] KEY_8    = 4'd8;
  localparam logic [3:0] KEY_9    = 4'd9;
  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  // First letter on each letter key (uppercase ASCII)
  localparam logic [7:0] BASE_2 = 8'h41; // A B C
  localparam logic [7:0] BASE_3 = 8'h44; // D E F
  localparam logic [7:0] BASE_4 = 8'h47; // G H I
  localparam logic [7:0] BASE_5 = 8'h4A; // J K L
  localparam logic [7:0] BASE_6 = 8'h4D; // M N O
  localparam logic [7:0] BASE_7 = 8'h50; // P Q R S
  localparam logic [7:0] BASE_8 = 8'h54; // T U V
  localparam logic [7:0] BASE_9 = 8'h57; // W X Y Z

  function automatic logic [7:0] letter_base(input logic [3:0] key_id);
    logic [7:0] base;
    case (key_id)
      KEY_2:   base = BASE_2;
      KEY_3:   base = BASE_3;
      KEY_4:   base = BASE_4;
      KEY_5:   base = BASE_5;
      KEY_6:   base = BASE_6;
      KEY_7:   base = BASE_7;
      KEY_8:   base = BASE_8;
      KEY_9:   base = BASE_9;
      default: base = 8'h00;
    endcase
    return base;
  endfunction

  function automatic logic onehot4(input logic [3:0] x);
    return (x != 4'd0) && ((x & (x - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/keypad_key_decode.sv
// keypad_key_decode
//   Purely combinational decode of the scanner's {row, col} code.
//   Ports:
//     cur_key      in  [7:0] {row[3:0], col[3:0]}
//     valid        out       exactly one row bit and one column bit set
//     key_id       out [3:0] key identifier (see keypad_pkg KEY_*)
//     is_letter    out       key carries letters (2..9)
//     letter_count out [2:0] letters on the key (3 or 4), 0 otherwise
`timescale 1ns/1ps
module keypad_key_decode
  import keypad_pkg::*;
(
  input  logic [7:0] cur_key,
  output logic       valid,
  output logic [3:0] key_id,
  output logic       is_letter,
  output logic [2:0] letter_count
);

  always_comb begin
    valid = onehot4(cur_key[7:4]) && onehot4(cur_key[3:0]);

    case (cur_key)
      CODE_0:    key_id = KEY_0;
      CODE_1:    key_id = KEY_1;
      CODE_2:    key_id = KEY_2;
      CODE_3:    key_id = KEY_3;
      CODE_4:    key_id = KEY_4;
      CODE_5:    key_id = KEY_5;
      CODE_6:    key_id = KEY_6;
      CODE_7:    key_id = KEY_7;
      CODE_8:    key_id = KEY_8;
      CODE_9:    key_id = KEY_9;
      CODE_A:    key_id = KEY_A;
      CODE_B:    key_id = KEY_B;
      CODE_C:    key_id = KEY_C;
      CODE_D:    key_id = KEY_D;
      CODE_STAR: key_id = KEY_STAR;
      CODE_HASH: key_id = KEY_HASH;
      // Malformed codes land on an inert key; valid is low for them anyway
      default:   key_id = KEY_1;
    endcase

    is_letter = valid && (key_id >= KEY_2) && (key_id <= KEY_9);

    if (!is_letter)
      letter_count = 3'd0;
    else if ((key_id == KEY_7) || (key_id == KEY_9))
      letter_count = 3'd4;
    else
      letter_count = 3'd3;
  end

endmodule

// File: rtl/keypad_letter_fsm.sv
// keypad_letter_fsm
//   Multi-tap letter entry: repeated taps on a letter key cycle through its
//   letters, '#' commits the previewed letter, '*' cancels, and an idle
//   timeout discards the selection. A committed letter is held until the
//   consumer acknowledges it; the scanner is paused while it waits.
//   Parameters:
//     TIMEOUT_CYCLES  tap-idle cycles before the pending letter is dropped
//     SCAN_DIV        clock cycles per scan_en pulse
//   Ports:
//     clk           in        system clock
//     nRst          in        asynchronous active-low reset
//     strobe        in        key-press pulse from scanner
//     cur_key       in  [7:0] {row[3:0], col[3:0]}
//     letter_ack    in        consumer accepts committed letter
//     scan_en       out       one-cycle column-advance pulse
//     scan_mode     out       scanner run enable (low while a letter waits)
//     cur_letter    out [7:0] ASCII preview of letter being tapped, 0 if none
//     letter        out [7:0] ASCII committed letter
//     letter_valid  out       committed letter available
`timescale 1ns/1ps
module keypad_letter_fsm
  import keypad_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 12_000_000,
  parameter int SCAN_DIV       = 12_000
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       strobe,
  input  logic [7:0] cur_key,
  input  logic       letter_ack,
  output logic       scan_en,
  output logic       scan_mode,
  output logic [7:0] cur_letter,
  output logic [7:0] letter,
  output logic       letter_valid
);

  // Guard against zero-width counters for degenerate parameter values
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  state_e           state_q, state_d;
  logic [3:0]       key_q, key_d;
  logic [1:0]       index_q, index_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       cur_letter_q, cur_letter_d;
  logic [7:0]       letter_q, letter_d;
  logic             letter_valid_q, letter_valid_d;
  logic             scan_en_q, scan_en_d;

  logic       dec_valid;
  logic [3:0] dec_key_id;
  logic       dec_is_letter;
  logic [2:0] dec_letter_count;

  logic       letter_press;
  logic       hash_press;
  logic       star_press;
  logic [1:0] tap_index;

  keypad_key_decode u_decode (
    .cur_key      (cur_key),
    .valid        (dec_valid),
    .key_id       (dec_key_id),
    .is_letter    (dec_is_letter),
    .letter_count (dec_letter_count)
  );

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q        <= ST_IDLE;
      key_q          <= KEY_0;
      index_q        <= 2'd0;
      timer_q        <= '0;
      div_q          <= '0;
      cur_letter_q   <= 8'h00;
      letter_q       <= 8'h00;
      letter_valid_q <= 1'b0;
      scan_en_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      key_q          <= key_d;
      index_q        <= index_d;
      timer_q        <= timer_d;
      div_q          <= div_d;
      cur_letter_q   <= cur_letter_d;
      letter_q       <= letter_d;
      letter_valid_q <= letter_valid_d;
      scan_en_q      <= scan_en_d;
    end
  end

  // --------------------------------------------------------- next-state logic
  always_comb begin
    // is_letter already implies a well-formed code
    letter_press = strobe && dec_is_letter;
    hash_press   = strobe && dec_valid && (dec_key_id == KEY_HASH);
    star_press   = strobe && dec_valid && (dec_key_id == KEY_STAR);

    // Next tap position on the same key, wrapping after its last letter
    if ({1'b0, index_q} == (dec_letter_count - 3'd1))
      tap_index = 2'd0;
    else
      tap_index = index_q + 2'd1;

    state_d        = state_q;
    key_d          = key_q;
    index_d        = index_q;
    timer_d        = timer_q;
    cur_letter_d   = cur_letter_q;
    letter_d       = letter_q;
    letter_valid_d = letter_valid_q;

    // Free-running scan divider, unaffected by the FSM
    div_d     = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    scan_en_d = (div_q == DIV_LAST);

    unique case (state_q)
      ST_IDLE: begin
        if (letter_press) begin
          state_d      = ST_TAP;
          key_d        = dec_key_id;
          index_d      = 2'd0;
          timer_d      = '0;
          cur_letter_d = letter_base(dec_key_id);
        end
      end

      ST_TAP: begin
        // Any acted-on press wins over a coincident timeout
        if (letter_press) begin
          timer_d = '0;
          if (dec_key_id == key_q) begin
            index_d      = tap_index;
            cur_letter_d = letter_base(key_q) + {6'd0, tap_index};
          end else begin
            key_d        = dec_key_id;
            index_d      = 2'd0;
            cur_letter_d = letter_base(dec_key_id);
          end
        end else if (hash_press) begin
          state_d        = ST_PENDING;
          letter_d       = cur_letter_q;
          letter_valid_d = 1'b1;
          cur_letter_d   = 8'h00;
          index_d        = 2'd0;
          timer_d        = '0;
        end else if (star_press || (timer_q == TMR_LAST)) begin
          state_d      = ST_IDLE;
          cur_letter_d = 8'h00;
          index_d      = 2'd0;
          timer_d      = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_PENDING: begin
        if (letter_ack) begin
          state_d        = ST_IDLE;
          letter_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------- output logic
  always_comb begin
    scan_mode    = (state_q != ST_PENDING);
    scan_en      = scan_en_q;
    cur_letter   = cur_letter_q;
    letter       = letter_q;
    letter_valid = letter_valid_q;
  end

endmodule

// File: tb/tb_keypad_letter_fsm.sv
`timescale 1ns/1ps
module tb_keypad_letter_fsm;

  // Key codes {row, col}, bit 7 = row0, bit 3 = col0
  localparam logic [7:0] K1 = 8'h88, K2 = 8'h84, K3 = 8'h82;
  localparam logic [7:0] K4 = 8'h48, K5 = 8'h44, K6 = 8'h42;
  localparam logic [7:0] K7 = 8'h28, K8 = 8'h24, K9 = 8'h22;
  localparam logic [7:0] KSTAR = 8'h18, K0 = 8'h14, KHASH = 8'h12;
  localparam logic [7:0] KBAD1 = 8'hC8; // two rows
  localparam logic [7:0] KBAD2 = 8'h26; // two columns

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       strobe = 1'b0;
  logic [7:0] cur_key = 8'h00;
  logic       letter_ack = 1'b0;
  logic       scan_en, scan_mode, letter_valid;
  logic [7:0] cur_letter, letter;

  int total = 0;
  int passed = 0;

  keypad_letter_fsm #(.TIMEOUT_CYCLES(100), .SCAN_DIV(10)) dut (
    .clk          (clk),
    .nRst         (nRst),
    .strobe       (strobe),
    .cur_key      (cur_key),
    .letter_ack   (letter_ack),
    .scan_en      (scan_en),
    .scan_mode    (scan_mode),
    .cur_letter   (cur_letter),
    .letter       (letter),
    .letter_valid (letter_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       stb;
    logic [7:0] key;
    logic       ack;
    logic [7:0] exp_cur;
    logic [7:0] exp_letter;
    logic       exp_valid;
    logic       exp_mode;
  } vec_t;

  vec_t vecs[32];

  function automatic vec_t mk(input logic s, input logic [7:0] k, input logic a,
                              input logic [7:0] c, input logic [7:0] l,
                              input logic v, input logic m);
    vec_t r;
    r.stb = s; r.key = k; r.ack = a;
    r.exp_cur = c; r.exp_letter = l; r.exp_valid = v; r.exp_mode = m;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      passed++;
  endtask

  // Apply inputs for one clock, then sample 1 ns after the edge
  task automatic step(input logic s, input logic [7:0] k, input logic a);
    strobe = s; cur_key = k; letter_ack = a;
    @(posedge clk); #1;
    strobe = 1'b0; letter_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int m;

    // ------------------------------------------------------------ reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_cur_letter", cur_letter, 8'h00);
    check("rst_letter", letter, 8'h00);
    check("rst_valid", letter_valid, 1'b0);
    check("rst_scan_en", scan_en, 1'b0);
    check("rst_scan_mode", scan_mode, 1'b1);
    nRst = 1'b1;

    // ------------------------------------------------------------ table
    vecs[0]  = mk(1, K2,    0, 8'h41, 8'h00, 0, 1);
    vecs[1]  = mk(1, K2,    0, 8'h42, 8'h00, 0, 1);
    vecs[2]  = mk(1, K2,    0, 8'h43, 8'h00, 0, 1);
    vecs[3]  = mk(1, KHASH, 0, 8'h00, 8'h43, 1, 0);
    vecs[4]  = mk(0, 8'h00, 0, 8'h00, 8'h43, 1, 0);
    vecs[5]  = mk(1, K5,    0, 8'h00, 8'h43, 1, 0);
    vecs[6]  = mk(0, 8'h00, 1, 8'h00, 8'h43, 0, 1);
    vecs[7]  = mk(1, KHASH, 0, 8'h00, 8'h43, 0, 1);
    vecs[8]  = mk(1, KSTAR, 0, 8'h00, 8'h43, 0, 1);
    vecs[9]  = mk(1, K7,    0, 8'h50, 8'h43, 0, 1);
    vecs[10] = mk(1, K7,    0, 8'h51, 8'h43, 0, 1);
    vecs[11] = mk(1, K7,    0, 8'h52, 8'h43, 0, 1);
    vecs[12] = mk(1, K7,    0, 8'h53, 8'h43, 0, 1);
    vecs[13] = mk(1, K7,    0, 8'h50, 8'h43, 0, 1);
    vecs[14] = mk(1, K9,    0, 8'h57, 8'h43, 0, 1);
    vecs[15] = mk(1, K1,    0, 8'h57, 8'h43, 0, 1);
    vecs[16] = mk(1, KBAD1, 0, 8'h57, 8'h43, 0, 1);
    vecs[17] = mk(1, K9,    0, 8'h58, 8'h43, 0, 1);
    vecs[18] = mk(1, KBAD2, 0, 8'h58, 8'h43, 0, 1);
    vecs[19] = mk(0, K9,    0, 8'h58, 8'h43, 0, 1);
    vecs[20] = mk(1, KSTAR, 0, 8'h00, 8'h43, 0, 1);
    vecs[21] = mk(0, 8'h00, 1, 8'h00, 8'h43, 0, 1);
    vecs[22] = mk(1, K0,    0, 8'h00, 8'h43, 0, 1);
    vecs[23] = mk(1, K3,    0, 8'h44, 8'h43, 0, 1);
    vecs[24] = mk(1, K3,    0, 8'h45, 8'h43, 0, 1);
    vecs[25] = mk(1, KHASH, 0, 8'h00, 8'h45, 1, 0);
    vecs[26] = mk(0, 8'h00, 1, 8'h00, 8'h45, 0, 1);
    vecs[27] = mk(1, K8,    0, 8'h54, 8'h45, 0, 1);
    vecs[28] = mk(1, K8,    0, 8'h55, 8'h45, 0, 1);
    vecs[29] = mk(1, K8,    0, 8'h56, 8'h45, 0, 1);
    vecs[30] = mk(1, K8,    0, 8'h54, 8'h45, 0, 1);
    vecs[31] = mk(1, KSTAR, 0, 8'h00, 8'h45, 0, 1);

    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) begin
      step(vecs[i].stb, vecs[i].key, vecs[i].ack);
      $display("vec %0d: strobe=%0b key=%02h ack=%0b -> cur=%02h letter=%02h valid=%0b mode=%0b",
               i, vecs[i].stb, vecs[i].key, vecs[i].ack, cur_letter, letter, letter_valid, scan_mode);
      check($sformatf("vec%0d_cur", i), cur_letter, vecs[i].exp_cur);
      check($sformatf("vec%0d_letter", i), letter, vecs[i].exp_letter);
      check($sformatf("vec%0d_valid", i), letter_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_mode", i), scan_mode, vecs[i].exp_mode);
    end

    // ------------------------------------------------ timeout discards letter
    step(1, K5, 0);
    check("to_press5", cur_letter, 8'h4A);
    repeat (99) step(0, 8'h00, 0);
    check("to_before_expiry", cur_letter, 8'h4A);
    step(0, 8'h00, 0);
    check("to_expired_cur", cur_letter, 8'h00);
    check("to_expired_valid", letter_valid, 1'b0);
    step(1, KHASH, 0);
    $display("timeout seq: hash after timeout -> cur=%02h valid=%0b", cur_letter, letter_valid);
    check("to_hash_ignored_cur", cur_letter, 8'h00);
    check("to_hash_ignored_valid", letter_valid, 1'b0);
    check("to_hash_ignored_mode", scan_mode, 1'b1);

    // ---------------------------------- press at exact timeout cycle wins
    step(1, K5, 0);
    check("exp_press5", cur_letter, 8'h4A);
    repeat (10) step(0, 8'h00, 0);
    step(1, KBAD1, 0);
    check("exp_bad_ignored", cur_letter, 8'h4A);
    repeat (88) step(0, 8'h00, 0);
    check("exp_still_tap", cur_letter, 8'h4A);
    step(1, K9, 0);
    $display("expiry seq: key 9 at timeout cycle -> cur=%02h", cur_letter);
    check("exp_press9_wins", cur_letter, 8'h57);
    repeat (99) step(0, 8'h00, 0);
    check("exp_timer_restart", cur_letter, 8'h57);
    step(0, 8'h00, 0);
    check("exp_second_timeout", cur_letter, 8'h00);

    // ------------------------------------- pending holds until acknowledged
    step(1, K3, 0);
    check("pend_press3", cur_letter, 8'h44);
    step(1, KHASH, 0);
    check("pend_commit_letter", letter, 8'h44);
    check("pend_commit_valid", letter_valid, 1'b1);
    for (int i = 0; i < 50; i++) begin
      step(1, K4, 0);
      check($sformatf("pend_hold%0d", i), {cur_letter, letter, letter_valid, scan_mode},
            {8'h00, 8'h44, 1'b1, 1'b0});
    end
    step(0, 8'h00, 1);
    $display("pending seq: ack -> letter=%02h valid=%0b mode=%0b", letter, letter_valid, scan_mode);
    check("pend_ack_valid", letter_valid, 1'b0);
    check("pend_ack_mode", scan_mode, 1'b1);
    step(1, K4, 0);
    check("pend_after_ack_press4", cur_letter, 8'h47);
    step(1, KSTAR, 0);
    check("pend_cancel", cur_letter, 8'h00);

    // ---------------------------------------- async reset during PENDING
    step(1, K2, 0);
    step(1, KHASH, 0);
    check("rstp_valid_before", letter_valid, 1'b1);
    #2 nRst = 1'b0;
    #1;
    $display("reset in pending: letter=%02h valid=%0b mode=%0b", letter, letter_valid, scan_mode);
    check("rstp_letter_async", letter, 8'h00);
    check("rstp_valid_async", letter_valid, 1'b0);
    check("rstp_mode_async", scan_mode, 1'b1);
    check("rstp_scan_en_async", scan_en, 1'b0);
    @(posedge clk); #1;
    nRst = 1'b1;

    // scan_en: first pulse 10 cycles after release, then every 10 cycles
    n = 0;
    while (n < 30) begin
      step(0, 8'h00, 0);
      n++;
      if (scan_en) break;
    end
    check("scan_first_pulse", n, 10);
    m = 0;
    while (m < 30) begin
      step(0, 8'h00, 0);
      m++;
      if (m == 1) check("scan_pulse_width", scan_en, 1'b0);
      if (scan_en) break;
    end
    $display("scan_en: first pulse after %0d cycles, period %0d cycles", n, m);
    check("scan_period", m, 10);

    // first valid press after reset release processed normally
    step(1, K6, 0);
    check("post_rst_press6", cur_letter, 8'h4D);

    // ------------------------------------------- async reset during TAP
    #2 nRst = 1'b0;
    #1;
    check("rstt_cur_async", cur_letter, 8'h00);
    @(posedge clk); #1;
    nRst = 1'b1;
    step(1, KHASH, 0);
    check("rstt_hash_ignored", letter_valid, 1'b0);
    step(1, K6, 0);
    check("rstt_press6", cur_letter, 8'h4D);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/keypad_letter_fsm.md
KEYPAD_LETTER_FSM -- requirements
Module: keypad_letter_fsm

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 12_000_000, tap-idle cycles before the pending letter is discarded (1 s at 12 MHz).
REQ-002 SHALL have parameter SCAN_DIV, default 12_000, clock cycles per scan_en pulse.
REQ-003 SHALL have port clk, input, 1, the single system clock.
REQ-004 SHALL have port nRst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port strobe, input, 1, key-press pulse from the keypad scanner.
REQ-006 SHALL have port cur_key, input, 8, {row[3:0], col[3:0]}; bit 7 = row0 and bit 3 = col0.
REQ-007 SHALL have port letter_ack, input, 1, consumer accepts letter.
REQ-008 SHALL have port scan_en, output, 1, one-cycle column-advance pulse to the scanner.
REQ-009 SHALL have port scan_mode, output, 1, scanner run enable.
REQ-010 SHALL have port cur_letter, output, 8, ASCII preview of the letter being tapped, 0 when none.
REQ-011 SHALL have port letter, output, 8, ASCII committed letter.
REQ-012 SHALL have port letter_valid, output, 1, committed letter available.

Function
REQ-013 Key layout SHALL be: row0 = 1 2 3 A; row1 = 4 5 6 B; row2 = 7 8 9 C; row3 = * 0 # D.
REQ-014 A press SHALL be valid only when strobe=1 and cur_key has exactly one row bit and exactly one column bit set; all other presses are ignored.
REQ-015 Letter keys SHALL be 2=ABC, 3=DEF, 4=GHI, 5=JKL, 6=MNO, 7=PQRS, 8=TUV, 9=WXYZ (uppercase ASCII); keys 1, 0 and A-D SHALL be ignored.
REQ-016 States SHALL be IDLE, TAP and PENDING.
REQ-017 IDLE, letter key: go to TAP; tap index=0; cur_letter=first letter of the key next cycle; timer cleared.
REQ-018 IDLE, '#' or '*': SHALL be ignored.
REQ-019 TAP, same key: index+1, wrapping after 3 letters (4 for keys 7 and 9); timer cleared.
REQ-020 TAP, different letter key: replaces the selection at index 0 with no commit; timer cleared.
REQ-021 TAP, '#': go to PENDING; letter=cur_letter and letter_valid=1 on the next cycle; cur_letter=0.
REQ-022 TAP, '*': go to IDLE; cur_letter=0.
REQ-023 In TAP the timer SHALL increment each cycle without a valid press; reaching TIMEOUT_CYCLES-1 SHALL go to IDLE and set cur_letter=0.
REQ-024 A valid press in the same cycle as timer expiry SHALL take priority over the timeout.
REQ-025 In PENDING: letter and letter_valid SHALL be held; all presses ignored; scan_mode=0.
REQ-026 In PENDING, letter_ack=1: letter_valid=0 on the next cycle and go to IDLE; letter_ack outside PENDING SHALL be ignored.
REQ-027 scan_mode SHALL be 1 in IDLE and TAP.
REQ-028 scan_en SHALL pulse for 1 cycle every SCAN_DIV cycles from a free-running divider, independent of state.
REQ-029 Counter widths SHALL be $clog2 of their parameters; both counters SHALL wrap to 0 and never overflow.

Reset
REQ-030 On nRst=0, immediately and asynchronously: state=IDLE, index=0, counters=0, cur_letter=0, letter=0, letter_valid=0, scan_en=0, scan_mode=1.
REQ-031 Reset asserted mid-TAP or mid-PENDING SHALL discard the letter without emitting letter_valid.
REQ-032 The first valid press after reset release SHALL be processed normally.

Structure
REQ-033 Package keypad_pkg SHALL hold the state enum, key-code constants (row/col one-hot pairs) and the letter table base ASCII values.
REQ-034 Combinational sub-module keypad_key_decode SHALL map cur_key to {valid, key_id[3:0], is_letter, letter_count}.
REQ-035 All registers SHALL sit in one always_ff block with asynchronous reset.

Verification
REQ-036 Press key 2 three times, then '#' -> cur_letter 'A','B','C' after each press; letter=8'h43 and letter_valid=1 one cycle after '#'.
REQ-037 Press key 7 five times -> cur_letter sequence P,Q,R,S,P (wrap at 4).
REQ-038 Press key 5, then idle TIMEOUT_CYCLES (test value 100) -> IDLE, cur_letter=0, no letter_valid; then press '#' -> ignored.
REQ-039 Key 3 then '#', hold letter_ack=0 for 50 cycles while pressing key 4 -> letter stays 'D', valid held, scan_mode=0; then letter_ack=1 -> valid=0 next cycle and state IDLE.
REQ-040 cur_key=8'b1100_1000 with strobe, then key 9 press at the exact timeout cycle -> the first press is ignored; the second yields cur_letter='W' and timer restarts.
REQ-041 Reset asserted during PENDING -> letter_valid=0 and letter=0 asynchronously; SCAN_DIV=10 -> scan_en period of exactly 10 cycles.
